// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between EXU and a valid/ready data-memory bus.
module lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_fault,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_wen,
    output logic [3:0]        req_wmask,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_rdata,
    output logic              resp_ready
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        op_q, op_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic              nop, bad;
    logic [1:0]        off;
    logic [DATA_W-1:0] s, ext;

    // Illegal encodings and misalignment are resolved at accept time so faults never touch the bus.
    assign nop = ~mem_rd_en & ~mem_wr_en;
    assign bad = (mem_rd_en & mem_wr_en) | (mem_op[1:0] == 2'b11) | (mem_op == 3'b110)
               | (mem_wr_en & mem_op[2]) | ((mem_op[1:0] == 2'b01) & addr[0])
               | ((mem_op[1:0] == 2'b10) & (addr[1:0] != 2'b00));

    assign off = addr_q[1:0];
    assign s   = resp_rdata >> {off, 3'b000};
    assign ext = op_q[1] ? s
               : op_q[0] ? {{(DATA_W-16){~op_q[2] & s[15]}}, s[15:0]}
               : {{(DATA_W-8){~op_q[2] & s[7]}}, s[7:0]};

    assign in_ready   = state_q == IDLE;
    assign req_valid  = state_q == REQ;
    assign resp_ready = state_q == RESP;
    assign out_valid  = state_q == DONE;
    assign out_rdata  = rdata_q;
    assign out_fault  = fault_q;
    assign req_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign req_wen    = wr_q;
    assign req_wdata  = wdata_q << {off, 3'b000};
    assign req_wmask  = ~wr_q ? 4'b0000
                      : op_q[1] ? 4'b1111
                      : op_q[0] ? 4'b0011 << off
                      : 4'b0001 << off;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        if (state_q == IDLE && in_valid) begin
            addr_d  = addr;
            wdata_d = wdata;
            op_d    = mem_op;
            rd_d    = mem_rd_en;
            wr_d    = mem_wr_en;
            rdata_d = '0;
            fault_d = ~nop & bad;
            state_d = (nop | bad) ? DONE : REQ;
        end else if (state_q == REQ && req_ready) begin
            state_d = RESP;
        end else if (state_q == RESP && resp_valid) begin
            rdata_d = rd_q ? ext : '0;
            state_d = DONE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller for the NPC core. It accepts the memory-access control fields produced by the instruction decoder (read enable, write enable, 3-bit memory op) together with the effective address and store data. It runs one transaction on the data-memory bus with valid/ready handshakes and returns sign/zero-extended load data, or an alignment fault, to write-back. It sits between EXU address generation and the data-memory port, one access in flight at a time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; byte lanes = 4)
---
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  access request from EXU
- in_ready  out  1  LSU can accept (high only in IDLE)
- mem_rd_en  in  1  decoder load enable
- mem_wr_en  in  1  decoder store enable
- mem_op  in  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
- addr  in  ADDR_W  effective byte address
- wdata  in  DATA_W  store data, LSB-aligned
- out_valid  out  1  one-cycle completion pulse
- out_rdata  out  DATA_W  extended load data (0 for stores/no-op/fault)
- out_fault  out  1  misaligned or illegal access, qualified by out_valid
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 0)
- req_wen  out  1  1 = write
- req_wmask  out  4  byte-lane strobe
- req_wdata  out  DATA_W  lane-shifted store data
- resp_valid  in  1  bus response valid (reads and writes)
- resp_rdata  in  DATA_W  read word
- resp_ready  out  1  high only in RESP

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE: in_ready=1. On in_valid: latch addr, wdata, mem_op, rd/wr into registers, then:
  - neither rd nor wr -> DONE, out_fault=0, out_rdata=0.
  - rd and wr both high, mem_op in {011,110,111}, store with mem_op in {100,101}, half with addr[0]=1, or word with addr[1:0]!=0 -> DONE with out_fault=1; no bus activity.
  - else -> REQ.
- REQ: req_valid=1; req_addr/req_wen/req_wmask/req_wdata driven from latched registers, stable until req_ready. On req_ready -> RESP.
- RESP: resp_ready=1; on resp_valid latch load result -> DONE. Responses outside RESP ignored.
- DONE: out_valid=1 for exactly one cycle -> IDLE.
- Write mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. req_wdata = wdata<<(8*addr[1:0]) (byte data replicated not required; unused lanes don't-care but driven from shift).
- Load: s = resp_rdata>>(8*addr[1:0]); 000 sext s[7:0], 001 sext s[15:0], 010 s, 100 zext s[7:0], 101 zext s[15:0]. Store completion returns out_rdata=0.
- Read requests drive req_wmask=0.

## Timing
- Reset: state IDLE; out_valid, out_fault, req_valid, resp_ready = 0; out_rdata and latched registers = 0; in_ready=1 from first cycle after rst deasserts.
- rst in any state -> IDLE next edge; in-flight bus transaction abandoned, late response ignored (resp_ready=0); no out_valid for aborted access.
- Best-case latency (req_ready and resp_valid asserted on first opportunity): accept at cycle 0, request handshake cycle 1, response cycle 2, out_valid cycle 3.
- Fault/no-op path: accept cycle 0, out_valid cycle 1.
- resp_valid concurrent with the req handshake is ignored; bus must respond at earliest the cycle after.
- in_ready=0 from cycle after accept until returning to IDLE; back-to-back throughput = 1 access per 4 cycles minimum.
- out_rdata/out_fault held from DONE until next accept.

## Test plan
- lw addr 0x80000008, resp_rdata 0xDEADBEEF, zero-wait bus -> req_addr 0x80000008, req_wmask 0, out_valid at cycle 3, out_rdata 0xDEADBEEF, out_fault 0.
- lb addr 0x80000003, resp 0x80112233 -> out_rdata 0xFFFFFF80; lbu same -> 0x00000080; lhu addr 0x..2 resp 0xBEEF1234 -> 0x0000BEEF.
- sh addr 0x80000006, wdata 0x0000ABCD -> req_wen 1, req_addr 0x80000004, req_wmask 1100, req_wdata[31:16]=0xABCD; out_rdata 0.
- lw addr 0x80000002 -> no req_valid ever, out_valid at cycle 1 with out_fault 1; sh addr 0x...1 same.
- req_ready low 5 cycles then high, resp_valid delayed 3 cycles -> req payload stable throughout, in_ready 0, exactly one out_valid pulse.
- rst asserted during RESP, resp_valid arrives 2 cycles later -> no out_valid, resp_ready 0, in_ready 1; next lw completes normally.
